bpu_pht_ctrl: RTL and testbench
===============================

// Module: bpu_pht_ctrl
// PURPOSE
//  Drives the pattern-history table RAM. It is the client side of the simple-dual-port table RAM (1W/1R, 1–2 cycle read).
//  - Clears the table after reset.
//  - Serves PC-indexed prediction lookups through the RAM read port.
//  - Writes saturating-counter updates from branch resolution through the write port.
//  - Hides read/write collisions, which return X in the RAM, by forwarding in-flight write data.
// PARAMETERS
//  ADDR      9     table index width; DEPTH = 2**ADDR entries
//  CTR_W     2     saturating counter width (RAM data width)
//  PIPELINE  0     RAM read latency select: 0 -> 1 cycle, 1 -> 2 cycles (must match the RAM)
//  INIT_CTR  1     counter value written during clear (weakly not-taken)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       synchronous active-low reset
//  lk_valid    in   1       lookup request
//  lk_pc       in   32      fetch PC; index = lk_pc[ADDR+1:2]
//  lk_ready    out  1       lookup accepted when lk_valid & lk_ready
//  rsp_valid   out  1       prediction valid
//  rsp_ctr     out  CTR_W   counter read for the lookup
//  rsp_taken   out  1       rsp_ctr[CTR_W-1]
//  upd_valid   in   1       update request
//  upd_pc      in   32      resolved branch PC (same index slice)
//  upd_ctr     in   CTR_W   counter value returned with the original prediction
//  upd_taken   in   1       actual outcome
//  upd_ready   out  1       update accepted when upd_valid & upd_ready
//  ram_we      out  1       RAM write enable
//  ram_waddr   out  ADDR    RAM write address
//  ram_wdata   out  CTR_W   RAM write data
//  ram_re      out  1       RAM read enable
//  ram_raddr   out  ADDR    RAM read address
//  ram_rdata   in   CTR_W   RAM read data, LAT = PIPELINE+1 cycles after ram_re
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - FSM goes to INIT; clear pointer = 0.
//    - Outputs: rsp_valid=0, lk_ready=0, upd_ready=0, ram_re=0, ram_we=0.
//    - All read-pipeline valid bits and forward flags are cleared.
//  - INIT:
//    - One write per cycle: ram_we=1, ram_waddr=ptr, ram_wdata=INIT_CTR; ptr increments.
//    - After address DEPTH-1 is written, go to RUN. INIT lasts exactly DEPTH cycles.
//    - Lookups and updates are not accepted; ram_re=0.
//    - Reset during INIT or RUN restarts INIT at address 0 and discards in-flight lookups.
//  - RUN: lk_ready=1 and upd_ready=1 every cycle (no back-pressure).
//  - Lookup:
//    - On accept: ram_re=1, ram_raddr=index (combinational from lk_pc).
//    - rsp_valid is asserted exactly LAT cycles later for one cycle.
//    - Responses come back in order; back-to-back lookups give back-to-back responses.
//  - Update:
//    - On accept: ram_we=1 same cycle, ram_waddr=index(upd_pc).
//    - ram_wdata = upd_taken ? sat_inc(upd_ctr) : sat_dec(upd_ctr).
//    - Saturation: all-ones stays all-ones on increment; 0 stays 0 on decrement.
//    - Arithmetic is unsigned, CTR_W bits.
//  - Forwarding (rsp_ctr must never carry RAM X):
//    - Each read-pipe stage holds {valid, addr, fwd, fwd_data}.
//    - A write at a stage's addr in any cycle from issue (same-cycle collision included) up to the cycle before rsp_valid sets fwd=1 and fwd_data=ram_wdata.
//    - The latest write wins.
//    - rsp_ctr = fwd ? fwd_data : ram_rdata.
//    - A write in the same cycle as rsp_valid is not reflected; it will appear in the next lookup.
//  - Simultaneous lookup and update on different indices: both proceed independently in the same cycle.
//  - Index wraps naturally: PC bits above ADDR+1 are ignored (aliasing allowed).
// STRUCTURE
//  - Shared package bpu_pkg holds:
//    - CTR_W, INIT_CTR defaults;
//    - state encoding typedef {ST_INIT, ST_RUN};
//    - function sat_upd(ctr, taken);
//    - function pht_index(pc).
//  - One natural sub-module, bpu_rd_track: LAT-deep shift register of {valid, addr, fwd, fwd_data} with write-snoop compare.
//  - The RAM itself is instantiated by the parent, not inside this block.
// TESTING
//  1. Reset, hold idle -> ram_we=1 for exactly 512 cycles, addresses 0..511, data 2'b01. lk_ready rises on cycle 513.
//  2. After INIT, lookup pc=0x100 (PIPELINE=0) -> ram_raddr=0x040. Next cycle rsp_valid=1, rsp_ctr=01, rsp_taken=0.
//  3. Saturation:
//     - update pc=0x100, upd_ctr=11, taken=1 -> ram_wdata=11;
//     - upd_ctr=00, taken=0 -> 00;
//     - upd_ctr=01, taken=1 -> 10.
//  4. Lookup and update pc=0x200 in the same cycle (upd_ctr=10, taken=1) -> rsp_ctr=11 via forward; RAM X never visible.
//  5. PIPELINE=1: lookup pc=0x300, update same index one cycle later (upd_ctr=01, taken=0) -> rsp_valid 2 cycles after the lookup, rsp_ctr=00.
//  6. Assert rst_n=0 mid-INIT (ptr=200) and mid-RUN with a lookup in flight -> ptr restarts at 0, no rsp_valid after reset.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch-predictor pattern-history table logic.
//  - Default counter width and the counter value written while clearing.
//  - Controller state encoding.
//  - sat_upd   : saturating counter step (increment on taken, decrement otherwise).
//  - pht_index : word-aligned PC to table index (PC bits above the index are dropped).
package bpu_pkg;

  localparam int CTR_W_DEF    = 2;
  localparam int INIT_CTR_DEF = 1;
  // Widest counter the helper below supports; callers cast down to their width.
  localparam int CTR_W_MAX    = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_e;

  // Unsigned saturating update of a ctr_w-bit counter.
  function automatic logic [CTR_W_MAX-1:0] sat_upd(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic                 taken,
    input int                   ctr_w
  );
    logic [CTR_W_MAX-1:0] ctr_max;
    ctr_max = '0;
    for (int i = 0; i < CTR_W_MAX; i++) begin
      if (i < ctr_w) ctr_max[i] = 1'b1;
    end
    if (taken) begin
      return (ctr >= ctr_max) ? ctr_max : ctr + 1'b1;
    end
    return (ctr == '0) ? '0 : ctr - 1'b1;
  endfunction

  // Index = pc[addr_w+1:2]; higher PC bits alias onto the same entry.
  function automatic logic [31:0] pht_index(
    input logic [31:0] pc,
    input int          addr_w
  );
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < addr_w) mask[i] = 1'b1;
    end
    return (pc >> 2) & mask;
  endfunction

endpackage

// File: rtl/bpu_rd_track.sv
// Read-pipeline tracker for the pattern-history table.
// A LAT-deep shift register follows every issued RAM read. Each stage holds
// {valid, addr, fwd, fwd_data}; any write that hits a stage's address while the
// read is in flight (including the issue cycle) is captured so the response can
// bypass the RAM, whose read data is undefined on a read/write collision.
// Ports:
//  clk, rst_n        clock, synchronous active-low reset (clears valid/fwd bits)
//  issue, issue_addr read accepted this cycle and its table index
//  we, waddr, wdata  write port activity being snooped
//  out_valid         read data from the RAM is due this cycle
//  out_fwd           use out_fwd_data instead of the RAM read data
//  out_fwd_data      youngest write data seen for this read's address
module bpu_rd_track #(
  parameter int ADDR  = 9,
  parameter int CTR_W = 2,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [ADDR-1:0]  issue_addr,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [CTR_W-1:0] wdata,
  output logic             out_valid,
  output logic             out_fwd,
  output logic [CTR_W-1:0] out_fwd_data
);

  logic [LAT-1:0]   valid_reg;
  logic [LAT-1:0]   fwd_reg;
  logic [ADDR-1:0]  addr_reg [LAT];
  logic [CTR_W-1:0] data_reg [LAT];

  // Stage inputs: stage 0 takes the new read, later stages take their predecessor.
  logic [LAT-1:0]   src_valid;
  logic [LAT-1:0]   src_fwd;
  logic [ADDR-1:0]  src_addr [LAT];
  logic [CTR_W-1:0] src_data [LAT];

  logic [LAT-1:0]   hit;
  logic [LAT-1:0]   fwd_next;
  logic [CTR_W-1:0] data_next [LAT];

  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_valid[gi] = issue;
        assign src_addr[gi]  = issue_addr;
        assign src_fwd[gi]   = 1'b0;
        assign src_data[gi]  = '0;
      end else begin : g_body
        assign src_valid[gi] = valid_reg[gi-1];
        assign src_addr[gi]  = addr_reg[gi-1];
        assign src_fwd[gi]   = fwd_reg[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
      end
      // A write this cycle overrides anything captured earlier: latest write wins.
      assign hit[gi]       = we && (waddr == src_addr[gi]);
      assign fwd_next[gi]  = hit[gi] | src_fwd[gi];
      assign data_next[gi] = hit[gi] ? wdata : src_data[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
      fwd_reg   <= '0;
    end else begin
      valid_reg <= src_valid;
      fwd_reg   <= fwd_next;
      for (int i = 0; i < LAT; i++) begin
        addr_reg[i] <= src_addr[i];
        data_reg[i] <= data_next[i];
      end
    end
  end

  // The output stage is not snooped: a write in the response cycle shows up
  // only in later lookups.
  assign out_valid    = valid_reg[LAT-1];
  assign out_fwd      = fwd_reg[LAT-1];
  assign out_fwd_data = data_reg[LAT-1];

endmodule

// File: rtl/bpu_pht_ctrl.sv
// Pattern-history table controller: client of an external 1W/1R table RAM.
// After reset it clears every entry to INIT_CTR (one write per cycle), then
// serves PC-indexed lookups on the read port and saturating-counter updates on
// the write port, forwarding in-flight write data over colliding reads.
// Ports:
//  clk, rst_n                        clock, synchronous active-low reset
//  lk_valid/lk_pc/lk_ready           lookup request (accepted when both valid and ready)
//  rsp_valid/rsp_ctr/rsp_taken       prediction, LAT = PIPELINE+1 cycles after accept
//  upd_valid/upd_pc/upd_ctr/upd_taken/upd_ready   resolved-branch counter update
//  ram_we/ram_waddr/ram_wdata        RAM write port
//  ram_re/ram_raddr/ram_rdata        RAM read port (data LAT cycles after ram_re)
module bpu_pht_ctrl
  import bpu_pkg::*;
#(
  parameter int ADDR     = 9,
  parameter int CTR_W    = CTR_W_DEF,
  parameter int PIPELINE = 0,
  parameter int INIT_CTR = INIT_CTR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  output logic             lk_ready,
  output logic             rsp_valid,
  output logic [CTR_W-1:0] rsp_ctr,
  output logic             rsp_taken,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [CTR_W-1:0] upd_ctr,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             ram_we,
  output logic [ADDR-1:0]  ram_waddr,
  output logic [CTR_W-1:0] ram_wdata,
  output logic             ram_re,
  output logic [ADDR-1:0]  ram_raddr,
  input  logic [CTR_W-1:0] ram_rdata
);

  localparam int LAT = PIPELINE + 1;

  pht_state_e       state_reg;
  logic [ADDR-1:0]  ptr_reg;

  logic             init_active;
  logic             run_active;
  logic             lk_fire;
  logic             upd_fire;
  logic [ADDR-1:0]  lk_idx;
  logic [ADDR-1:0]  upd_idx;
  logic [CTR_W-1:0] upd_wdata;
  logic             trk_fwd;
  logic [CTR_W-1:0] trk_fwd_data;

  // Clear sequence: ptr walks 0..DEPTH-1, leaving INIT once the last entry is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          ptr_reg <= ptr_reg + 1'b1;
          if (ptr_reg == '1) state_reg <= ST_RUN;
        end
        ST_RUN:  state_reg <= ST_RUN;
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  // Qualify with rst_n so nothing is written or accepted while reset is held.
  assign init_active = rst_n && (state_reg == ST_INIT);
  assign run_active  = rst_n && (state_reg == ST_RUN);

  assign lk_ready  = run_active;
  assign upd_ready = run_active;
  assign lk_fire   = lk_valid  & lk_ready;
  assign upd_fire  = upd_valid & upd_ready;

  assign lk_idx    = ADDR'(pht_index(lk_pc, ADDR));
  assign upd_idx   = ADDR'(pht_index(upd_pc, ADDR));
  assign upd_wdata = CTR_W'(sat_upd(CTR_W_MAX'(upd_ctr), upd_taken, CTR_W));

  assign ram_re    = lk_fire;
  assign ram_raddr = lk_idx;

  assign ram_we    = init_active | upd_fire;
  assign ram_waddr = init_active ? ptr_reg : upd_idx;
  assign ram_wdata = init_active ? CTR_W'(INIT_CTR) : upd_wdata;

  bpu_rd_track #(
    .ADDR  (ADDR),
    .CTR_W (CTR_W),
    .LAT   (LAT)
  ) u_rd_track (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue        (lk_fire),
    .issue_addr   (lk_idx),
    .we           (ram_we),
    .waddr        (ram_waddr),
    .wdata        (ram_wdata),
    .out_valid    (rsp_valid),
    .out_fwd      (trk_fwd),
    .out_fwd_data (trk_fwd_data)
  );

  assign rsp_ctr   = trk_fwd ? trk_fwd_data : ram_rdata;
  assign rsp_taken = rsp_ctr[CTR_W-1];

endmodule

// File: tb/tb_bpu_pht_ctrl.sv
// Bench for bpu_pht_ctrl: two instances (PIPELINE=0 and PIPELINE=1) share the
// same stimulus, each with its own behavioural table RAM that returns X on a
// same-address read/write collision. The reference model is a plain table of
// counters: a lookup issued in cycle t with latency L returns the table content
// as it stands at the start of cycle t+L.
module tb_bpu_pht_ctrl;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_ctr;
  logic        upd_taken;

  logic        lk_ready_w  [2];
  logic        rsp_valid_w [2];
  logic [1:0]  rsp_ctr_w   [2];
  logic        rsp_taken_w [2];
  logic        upd_ready_w [2];
  logic        ram_we_w    [2];
  logic [8:0]  ram_waddr_w [2];
  logic [1:0]  ram_wdata_w [2];
  logic        ram_re_w    [2];
  logic [8:0]  ram_raddr_w [2];
  logic [1:0]  ram_rdata_w [2];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    int due;
    int idx;
    int d;
  } pend_t;
  pend_t pend[$];
  int tbl [DEPTH];

  always #5 clk = ~clk;

  bpu_pht_ctrl #(.ADDR(9), .CTR_W(2), .PIPELINE(0), .INIT_CTR(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready_w[0]),
    .rsp_valid(rsp_valid_w[0]), .rsp_ctr(rsp_ctr_w[0]), .rsp_taken(rsp_taken_w[0]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ctr(upd_ctr), .upd_taken(upd_taken),
    .upd_ready(upd_ready_w[0]),
    .ram_we(ram_we_w[0]), .ram_waddr(ram_waddr_w[0]), .ram_wdata(ram_wdata_w[0]),
    .ram_re(ram_re_w[0]), .ram_raddr(ram_raddr_w[0]), .ram_rdata(ram_rdata_w[0])
  );

  bpu_pht_ctrl #(.ADDR(9), .CTR_W(2), .PIPELINE(1), .INIT_CTR(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready_w[1]),
    .rsp_valid(rsp_valid_w[1]), .rsp_ctr(rsp_ctr_w[1]), .rsp_taken(rsp_taken_w[1]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ctr(upd_ctr), .upd_taken(upd_taken),
    .upd_ready(upd_ready_w[1]),
    .ram_we(ram_we_w[1]), .ram_waddr(ram_waddr_w[1]), .ram_wdata(ram_wdata_w[1]),
    .ram_re(ram_re_w[1]), .ram_raddr(ram_raddr_w[1]), .ram_rdata(ram_rdata_w[1])
  );

  // Behavioural table RAMs: instance gi has read latency gi+1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ram
    logic [1:0] mem [DEPTH];
    logic [1:0] q0;
    logic [1:0] q1;
    always @(posedge clk) begin
      if (ram_we_w[gi]) mem[ram_waddr_w[gi]] <= ram_wdata_w[gi];
      if (ram_re_w[gi])
        q0 <= (ram_we_w[gi] && ram_waddr_w[gi] == ram_raddr_w[gi]) ? 2'bxx : mem[ram_raddr_w[gi]];
      q1 <= q0;
    end
    assign ram_rdata_w[gi] = (gi == 0) ? q0 : q1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sat(input int c, input bit taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // Hold reset for n sampled edges, checking quiet outputs, then release.
  task automatic hold_reset(input int n);
    rst_n = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst d%0d ram_we", d), ram_we_w[d], 0);
        chk($sformatf("rst d%0d ram_re", d), ram_re_w[d], 0);
        chk($sformatf("rst d%0d lk_ready", d), lk_ready_w[d], 0);
        chk($sformatf("rst d%0d upd_ready", d), upd_ready_w[d], 0);
        chk($sformatf("rst d%0d rsp_valid", d), rsp_valid_w[d], 0);
      end
      $display("reset cycle: outputs quiet");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend.delete();
  endtask

  // Walk n clear cycles expecting addresses 0..n-1 written with INIT_CTR.
  task automatic run_init(input int n);
    int bad;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bad = mismatched;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("init d%0d ram_we @%0d", d, i), ram_we_w[d], 1);
        chk($sformatf("init d%0d ram_waddr @%0d", d, i), ram_waddr_w[d], i);
        chk($sformatf("init d%0d ram_wdata @%0d", d, i), ram_wdata_w[d], 1);
        chk($sformatf("init d%0d lk_ready @%0d", d, i), lk_ready_w[d], 0);
        chk($sformatf("init d%0d ram_re @%0d", d, i), ram_re_w[d], 0);
      end
      if (i == 0 || i == n - 1 || bad != mismatched)
        $display("init cycle %0d: addr=%0d data=%0d", i, ram_waddr_w[0], ram_wdata_w[0]);
      @(posedge clk); #1;
    end
    for (int k = 0; k < DEPTH; k++) tbl[k] = 1;
  endtask

  // One RUN cycle: drive, check against the model at the falling edge, update model.
  task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input logic [1:0] uctr, input bit utk);
    int li;
    int ui;
    int wexp;
    pend_t keep[$];
    lk_valid = lv; lk_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_ctr = uctr; upd_taken = utk;
    li = int'(lpc[10:2]);
    ui = int'(upc[10:2]);
    wexp = exp_sat(int'(uctr), utk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit due_hit;
      int due_idx;
      due_hit = 1'b0;
      due_idx = 0;
      foreach (pend[k]) begin
        if (pend[k].due == cyc && pend[k].d == d) begin
          due_hit = 1'b1;
          due_idx = pend[k].idx;
        end
      end
      chk($sformatf("c%0d d%0d lk_ready", cyc, d), lk_ready_w[d], 1);
      chk($sformatf("c%0d d%0d upd_ready", cyc, d), upd_ready_w[d], 1);
      chk($sformatf("c%0d d%0d ram_re", cyc, d), ram_re_w[d], 32'(lv));
      if (lv) chk($sformatf("c%0d d%0d ram_raddr", cyc, d), ram_raddr_w[d], li);
      chk($sformatf("c%0d d%0d ram_we", cyc, d), ram_we_w[d], 32'(uv));
      if (uv) begin
        chk($sformatf("c%0d d%0d ram_waddr", cyc, d), ram_waddr_w[d], ui);
        chk($sformatf("c%0d d%0d ram_wdata", cyc, d), ram_wdata_w[d], wexp);
      end
      chk($sformatf("c%0d d%0d rsp_valid", cyc, d), rsp_valid_w[d], 32'(due_hit));
      if (due_hit) begin
        chk($sformatf("c%0d d%0d rsp_ctr", cyc, d), rsp_ctr_w[d], tbl[due_idx]);
        chk($sformatf("c%0d d%0d rsp_taken", cyc, d), rsp_taken_w[d], (tbl[due_idx] >> 1) & 1);
      end
    end
    $display("cycle %0d: lk=%0d idx=%03h upd=%0d idx=%03h wdata=%0d | rsp0=%0d/%0d rsp1=%0d/%0d",
             cyc, lv, li, uv, ui, ram_wdata_w[0], rsp_valid_w[0], rsp_ctr_w[0],
             rsp_valid_w[1], rsp_ctr_w[1]);
    foreach (pend[k]) if (pend[k].due != cyc) keep.push_back(pend[k]);
    pend = keep;
    if (uv) tbl[ui] = wexp;
    if (lv) begin
      pend.push_back('{due: cyc + 1, idx: li, d: 0});
      pend.push_back('{due: cyc + 2, idx: li, d: 1});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; lk_valid = 1'b0; lk_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ctr = '0; upd_taken = 1'b0;

    // Power-up reset, partial clear, reset again at ptr=200, then a full clear.
    hold_reset(3);
    run_init(200);
    hold_reset(2);
    run_init(DEPTH);

    // First RUN cycle idle: ready high, no writes.
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    // Plain lookup of a freshly cleared entry.
    step(1, 32'h100, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    // Saturation corners.
    step(0, 32'h0, 1, 32'h100, 2'd3, 1);
    step(0, 32'h0, 1, 32'h100, 2'd0, 0);
    step(0, 32'h0, 1, 32'h100, 2'd1, 1);
    step(1, 32'h100, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    // Same-cycle lookup and update of one index.
    step(1, 32'h200, 1, 32'h200, 2'd2, 1);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    // Update one cycle after the lookup of the same index.
    step(1, 32'h300, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 1, 32'h300, 2'd1, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    // Aliased PC (upper bits differ, same index) and independent indices together.
    step(1, 32'hABC0_0100, 1, 32'h0000_0104, 2'd1, 1);
    step(1, 32'h0000_0104, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);

    // Random traffic over a few indices so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lp;
      logic [31:0] up;
      lp = ($urandom & 32'hFFFF_F803) | (32'($urandom_range(0, 7)) << 2);
      up = ($urandom & 32'hFFFF_F803) | (32'($urandom_range(0, 7)) << 2);
      step(1'($urandom_range(0, 1)), lp, 1'($urandom_range(0, 1)), up,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset mid-RUN with a lookup in flight: no response afterwards, clear restarts at 0.
    step(1, 32'h108, 0, 32'h0, 2'd0, 0);
    hold_reset(2);
    run_init(DEPTH);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    step(1, 32'h108, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);
    step(0, 32'h0, 0, 32'h0, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
